fixed_to_float16: RTL
=====================

Name: fixed_to_float16

Overview:
- Encoder for the team's 16-bit custom float format consumed by float_div and float_multiply.
- Converts a signed two's-complement fixed-point word into that float, using an iterative one-bit-per-cycle normaliser.
- Sits upstream of the float datapath and feeds converted operands through a valid/ready handshake.
- Float format: bit15 = sign (1 = positive, 0 = negative); bits14:10 = exponent field e, biased by 16; bits9:0 = mantissa M with M[9]=1 when normalised. Value = ±(M/512)·2^(e−16).

Parameters:
- DATA_W, 24, width of the input fixed-point word (valid range 10..32).
- FRAC_W, 8, number of fractional bits in the input; input value = in_data / 2^FRAC_W.

Ports:
- clock  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input word present.
- in_ready  out  1  block can accept a word; high only in IDLE.
- in_data  in  DATA_W  signed two's-complement fixed-point input.
- out_valid  out  1  out_data holds a result.
- out_ready  in  1  downstream accepts the result.
- out_data  out  16  encoded float.
- out_ovf  out  1  result saturated; valid while out_valid is high.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, out_valid=0, out_data=16'h0000, out_ovf=0, internal shift and count registers cleared. in_ready=1 once rst_n is released. Reset mid-conversion aborts the conversion with no output.
- FSM states: IDLE, NORM, PACK, HOLD.
- IDLE:
  - The handshake occurs when in_valid & in_ready.
  - On handshake, capture sign = in_data[DATA_W−1] and mag = |in_data| as DATA_W-bit unsigned. The most negative input gives mag = 2^(DATA_W−1) exactly.
  - Clear the shift count s. Go to PACK with zero_flag=1 if mag==0, otherwise go to NORM.
- NORM:
  - If mag[DATA_W−1]==1, go to PACK.
  - Otherwise shift mag left by 1 and increment s.
  - Exactly one shift per cycle.
- PACK (one cycle, computes and registers the result):
  - p = DATA_W−1−s.
  - e = p − FRAC_W + 16, computed signed with at least 8 bits.
  - M = mag[DATA_W−1 : DATA_W−10]. Lower bits are truncated (round toward zero on magnitude). If DATA_W=10 there are no lower bits.
  - Normal result: e in 0..31 → out_data = {~sign, e[4:0], M}.
  - Overflow: e > 31 → out_data = {~sign, 5'd31, 10'd1023}, out_ovf=1.
  - Underflow: e < 0, or zero_flag → out_data = 16'h8000 (positive zero: sign 1, exponent 0, mantissa 0), out_ovf=0.
  - Set out_valid=1 and go to HOLD.
- HOLD:
  - out_data and out_ovf stay stable while out_valid=1 and out_ready=0.
  - On out_valid & out_ready: out_valid=0 and go to IDLE.
  - in_ready rises the cycle after the output handshake. There is no overlap of input and output handshakes.
- Latency: out_valid is asserted at the (s+2)-th rising edge after the input handshake edge, where s = number of leading zeros of mag. Zero input takes 1 cycle. Worst case is DATA_W+1 cycles (input 1 LSB).
- in_ready is combinational from state (IDLE only). in_valid is ignored outside IDLE.

Test Plan (defaults DATA_W=24, FRAC_W=8, out_ready=1 unless stated):
- in_data=24'h000100 (1.0) → out_data=16'hC200, out_ovf=0, out_valid 17 cycles after accept (s=15). in_data=24'hFFFF00 (−1.0) → 16'h4200.
- in_data=24'h000300 (3.0) → 16'hC700. in_data=24'h000C03 (≈12.0117) → 16'hCF00, which is truncated to 12.0.
- Extremes:
  - 24'h7FFFFF → 16'hFBFF.
  - 24'h800000 → 16'h7E00 (e=31, M=512).
  - 24'h000001 → 16'hA200 with out_valid 25 cycles after accept.
  - 24'h000000 → 16'h8000 after 1 cycle.
- Overflow with FRAC_W=0, DATA_W=24, in_data=24'h400000 (p=22, e=38) → 16'hFFFF, out_ovf=1. Underflow with FRAC_W=24, in_data=1 (e=−8) → 16'h8000.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid → out_data stable, in_ready=0 and in_valid ignored throughout. Release out_ready → one handshake, in_ready=1 the next cycle. Back-to-back input stream with random out_ready → results in order, none lost or duplicated, each matching a reference model of the format.
- Drop rst_n asynchronously mid-NORM (input 24'h000001, 5 cycles in) → out_valid=0 and out_data=0 immediately, with no output after release. in_ready=1 after release, and the next conversion is correct.

Source files
------------

// File: rtl/fixed_to_float16.sv
// Signed fixed-point to 16-bit custom float encoder.
// Normalises the magnitude with one left shift per cycle, then packs sign, exponent and mantissa.
module fixed_to_float16 #(
    parameter int DATA_W = 24,
    parameter int FRAC_W = 8
) (
    input  logic              clock,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [15:0]       out_data,
    output logic              out_ovf
);

    // Once normalised, the biased exponent is this constant minus the shift count.
    localparam int E_BASE = DATA_W - 1 + 16 - FRAC_W;

    typedef enum logic [1:0] {IDLE, NORM, PACK, HOLD} state_t;

    state_t              state_q;
    logic [DATA_W-1:0]   mag_q;
    logic [5:0]          cnt_q;
    logic                sign_q;
    logic                zero_q;
    logic                out_valid_q;
    logic                out_ovf_q;
    logic [15:0]         out_data_q;

    logic [DATA_W-1:0]   abs_in;
    logic signed [9:0]   exp_d;
    logic [9:0]          mant_d;
    logic [15:0]         data_d;
    logic                ovf_d;

    // Two's-complement negate; the most negative input maps to exactly 2^(DATA_W-1).
    assign abs_in = in_data[DATA_W-1] ? (~in_data + DATA_W'(1)) : in_data;

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ovf   = out_ovf_q;

    always_comb begin
        exp_d  = 10'(E_BASE) - 10'(cnt_q);
        mant_d = mag_q[DATA_W-1 -: 10];
        data_d = {~sign_q, exp_d[4:0], mant_d};
        ovf_d  = 1'b0;
        if (zero_q || (exp_d < 10'sd0)) begin
            data_d = 16'h8000;
        end else if (exp_d > 10'sd31) begin
            data_d = {~sign_q, 5'd31, 10'h3FF};
            ovf_d  = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mag_q       <= '0;
            cnt_q       <= '0;
            sign_q      <= 1'b0;
            zero_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_ovf_q   <= 1'b0;
            out_data_q  <= 16'h0000;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        sign_q  <= in_data[DATA_W-1];
                        mag_q   <= abs_in;
                        cnt_q   <= '0;
                        zero_q  <= (abs_in == '0);
                        state_q <= (abs_in == '0) ? PACK : NORM;
                    end
                end
                NORM: begin
                    if (mag_q[DATA_W-1]) begin
                        state_q <= PACK;
                    end else begin
                        mag_q <= mag_q << 1;
                        cnt_q <= cnt_q + 6'd1;
                    end
                end
                PACK: begin
                    out_data_q  <= data_d;
                    out_ovf_q   <= ovf_d;
                    out_valid_q <= 1'b1;
                    state_q     <= HOLD;
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
